// File: rtl/fifo_sr_flags_if.sv
// Handshake/data bundle for the shift-register FIFO with occupancy and error flags.
// Latency: pure wiring, no storage.
// Backpressure: none in the bundle itself; the FIFO reports full/overflow instead of stalling.
// master: producer/consumer side (drives write/read/dataIn/clearErr, observes status)
// slave : FIFO side (observes strobes, drives dataOut, count and all flags)
interface fifo_sr_flags_if #(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 4
);
    logic                  write;
    logic                  read;
    logic [WIDTH-1:0]      dataIn;
    logic                  clearErr;
    logic [WIDTH-1:0]      dataOut;
    logic [LOG2_DEPTH:0]   count;
    logic                  dataPresent;
    logic                  halfFull;
    logic                  almostFull;
    logic                  almostEmpty;
    logic                  full;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output write, read, dataIn, clearErr,
        input  dataOut, count, dataPresent, halfFull, almostFull, almostEmpty,
               full, overflow, underflow
    );

    modport slave (
        input  write, read, dataIn, clearErr,
        output dataOut, count, dataPresent, halfFull, almostFull, almostEmpty,
               full, overflow, underflow
    );
endinterface

// File: rtl/fifo_sr_flags.sv
// Shift-register FWFT FIFO with full occupancy count, threshold flags and sticky error flags.
// Latency: a written word is visible on dataOut one cycle after its write edge; flags decode count with no extra delay.
// Backpressure: none; writes while full (no read) are dropped and flagged, reads while empty are flagged.
// Ports: clk, rst (synchronous, active-high); bus (slave modport) carries write/read/dataIn/clearErr
//        in and dataOut/count/dataPresent/halfFull/almostFull/almostEmpty/full/overflow/underflow out.
module fifo_sr_flags #(
    parameter int WIDTH        = 8,
    parameter int LOG2_DEPTH   = 4,
    parameter int ALMOST_FULL  = 12,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic            clk,
    input  logic            rst,
    fifo_sr_flags_if.slave  bus
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int CW    = LOG2_DEPTH + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] HALF_C  = CW'(DEPTH / 2);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL);
    localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_m1;
    logic [LOG2_DEPTH-1:0] rd_idx;
    logic                  is_full;
    logic                  is_empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovf_evt;
    logic                  unf_evt;
    logic                  ovf_q;
    logic                  unf_q;

    assign is_full  = (count_q == DEPTH_C);
    assign is_empty = (count_q == '0);

    // A read frees the tail slot in the same edge, so a full FIFO can still accept a write.
    assign wr_acc  = bus.write & (~is_full | bus.read);
    assign rd_acc  = bus.read & ~is_empty;
    assign ovf_evt = bus.write & is_full & ~bus.read;
    assign unf_evt = bus.read & is_empty;

    // Words enter at index 0 and age upward; the oldest sits at count-1.
    // Storage is not reset; a write coinciding with rst is discarded.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                mem[i] <= mem[i-1];
            end
            mem[0] <= bus.dataIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // A fresh error beats clearErr in the same cycle so no event is ever lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_evt)           ovf_q <= 1'b1;
            else if (bus.clearErr) ovf_q <= 1'b0;
            if (unf_evt)           unf_q <= 1'b1;
            else if (bus.clearErr) unf_q <= 1'b0;
        end
    end

    // When count is DEPTH, count-1 still fits in the low LOG2_DEPTH bits.
    assign count_m1 = count_q - 1'b1;
    assign rd_idx   = count_m1[LOG2_DEPTH-1:0];

    assign bus.dataOut     = is_empty ? '0 : mem[rd_idx];
    assign bus.count       = count_q;
    assign bus.dataPresent = ~is_empty;
    assign bus.halfFull    = (count_q >= HALF_C);
    assign bus.almostFull  = (count_q >= AF_C);
    assign bus.almostEmpty = (count_q <= AE_C);
    assign bus.full        = is_full;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;
endmodule

// File: tb/tb_fifo_sr_flags.sv
// Self-checking bench for fifo_sr_flags: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_fifo_sr_flags;
    localparam int WIDTH        = 8;
    localparam int LOG2_DEPTH   = 4;
    localparam int DEPTH        = 16;
    localparam int ALMOST_FULL  = 12;
    localparam int ALMOST_EMPTY = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_sr_flags_if #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH)) bus ();

    fifo_sr_flags #(
        .WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH),
        .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference model: oldest word at the front of the queue.
    logic [WIDTH-1:0] q[$];
    bit               m_ovf;
    bit               m_unf;
    int               errors = 0;
    int               checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count",       32'(bus.count),       32'(n));
        chk("dataOut",     32'(bus.dataOut),     (n > 0) ? 32'(q[0]) : 32'd0);
        chk("dataPresent", 32'(bus.dataPresent), 32'(n != 0));
        chk("halfFull",    32'(bus.halfFull),    32'(n >= DEPTH / 2));
        chk("almostFull",  32'(bus.almostFull),  32'(n >= ALMOST_FULL));
        chk("almostEmpty", 32'(bus.almostEmpty), 32'(n <= ALMOST_EMPTY));
        chk("full",        32'(bus.full),        32'(n == DEPTH));
        chk("overflow",    32'(bus.overflow),    32'(m_ovf));
        chk("underflow",   32'(bus.underflow),   32'(m_unf));
    endtask

    // Drive one cycle of inputs, advance one edge, update the model, then check 1 time unit later.
    task automatic step(input bit w, input bit r, input logic [WIDTH-1:0] d,
                        input bit ce, input bit rs);
        bit ovf_e, unf_e, can_pop;
        bus.write    = w;
        bus.read     = r;
        bus.dataIn   = d;
        bus.clearErr = ce;
        rst          = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            ovf_e   = w && (q.size() == DEPTH) && !r;
            unf_e   = r && (q.size() == 0);
            can_pop = r && (q.size() > 0);
            if (can_pop) void'(q.pop_front());
            if (w && !ovf_e) q.push_back(d);
            m_ovf = ovf_e ? 1'b1 : (ce ? 1'b0 : m_ovf);
            m_unf = unf_e ? 1'b1 : (ce ? 1'b0 : m_unf);
        end
        #1;
        check_all();
    endtask

    initial begin
        bus.write = 0; bus.read = 0; bus.dataIn = '0; bus.clearErr = 0;
        #2;

        // Reset state
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 1);
        chk("reset_count", 32'(bus.count), 32'd0);

        // 1: three writes then three reads
        step(1, 0, 8'h11, 0, 0);
        step(1, 0, 8'h22, 0, 0);
        step(1, 0, 8'h33, 0, 0);
        chk("t1_head", 32'(bus.dataOut), 32'h11);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0, 0);

        // 2: fill to 16, then one overflowing write
        for (int i = 0; i < 16; i++) step(1, 0, 8'(i), 0, 0);
        step(1, 0, 8'hEE, 0, 0);
        chk("t2_ovf", 32'(bus.overflow), 32'd1);
        chk("t2_head", 32'(bus.dataOut), 32'h00);

        // 3: full with simultaneous read+write, then drain
        step(1, 1, 8'hAA, 0, 0);
        chk("t3_head", 32'(bus.dataOut), 32'h01);
        for (int i = 0; i < 15; i++) step(0, 1, 8'h00, 0, 0);
        chk("t3_last", 32'(bus.dataOut), 32'hAA);
        step(0, 1, 8'h00, 0, 0);

        // 4: underflow, then read+write on empty
        step(0, 1, 8'h00, 0, 0);
        step(1, 1, 8'h5C, 0, 0);
        chk("t4_head", 32'(bus.dataOut), 32'h5C);

        // 5: clearErr alone, then clearErr racing an overflow
        for (int i = 0; i < 15; i++) step(1, 0, 8'(8'h40 + i), 0, 0);
        step(1, 0, 8'hFF, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        chk("t5_clr", 32'(bus.overflow), 32'd0);
        step(1, 0, 8'hFE, 1, 0);
        chk("t5_race", 32'(bus.overflow), 32'd1);

        // 6: count=5 with both flags set, rst together with write
        for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0, 0);
        step(0, 1, 8'h00, 0, 0);
        for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h80 + i), 0, 0);
        step(1, 0, 8'h99, 0, 0);
        for (int i = 0; i < 11; i++) step(0, 1, 8'h00, 0, 0);
        chk("t6_pre", 32'(bus.count), 32'd5);
        step(1, 0, 8'h77, 0, 1);
        step(1, 0, 8'h31, 0, 0);
        chk("t6_head", 32'(bus.dataOut), 32'h31);

        // Random traffic, alternating fill-biased and drain-biased phases
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 300; i++) begin
                bit w, r, ce, rs;
                w  = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 75 : 25));
                r  = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 25 : 75));
                ce = ($urandom_range(0, 15) == 0);
                rs = ($urandom_range(0, 199) == 0);
                step(w, r, 8'($urandom), ce, rs);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_sr_flags.md
Name: fifo_sr_flags

Overview:
Parametrised shift-register FIFO with a full occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It is the next-generation UART/peripheral buffer for the PicoIO blocks: all 2**LOG2_DEPTH entries are usable, and misuse is reported instead of being silently absorbed. The output is first-word-fall-through: the oldest word is always visible on dataOut.

Parameters:
WIDTH, 8, data word width in bits (>=1)
LOG2_DEPTH, 4, log2 of FIFO depth; DEPTH = 2**LOG2_DEPTH (>=1)
ALMOST_FULL, 12, almostFull asserts when count >= ALMOST_FULL (1..DEPTH)
ALMOST_EMPTY, 2, almostEmpty asserts when count <= ALMOST_EMPTY (0..DEPTH-1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
write  in  1  write strobe, one entry per cycle asserted
read  in  1  read strobe, pops oldest entry per cycle asserted
dataIn  in  WIDTH  data to write
clearErr  in  1  clears sticky overflow/underflow
dataOut  out  WIDTH  oldest stored word (FWFT); 0 when empty
count  out  LOG2_DEPTH+1  current occupancy, 0..DEPTH
dataPresent  out  1  count != 0
halfFull  out  1  count >= DEPTH/2
almostFull  out  1  count >= ALMOST_FULL
almostEmpty  out  1  count <= ALMOST_EMPTY
full  out  1  count == DEPTH
overflow  out  1  sticky: write attempted while full, with no read that cycle
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset clock clk; reset rst, synchronous, active-high. rst wins over every other input that cycle.
- Reset values: count=0, overflow=0, underflow=0; derived flags follow count (dataPresent=0, halfFull=0, full=0, almostFull=0 unless ALMOST_FULL=0, almostEmpty=1, dataOut=0). Memory contents are not cleared.
- Storage: DEPTH-word shift register. An accepted write shifts mem[i] <= mem[i-1] and loads mem[0] <= dataIn.
- dataOut is combinational: mem[count-1] when count>0, otherwise 0. It is valid in the same cycle count becomes nonzero (one cycle after the write edge).
- Write accepted iff write & (count<DEPTH | read). Read accepted iff read & count>0.
- Count update, per edge (write and read here mean accepted):
  - write only: count+1.
  - read only: count-1.
  - both: count unchanged; the shift is done and the new oldest word is at index count-1.
  - neither: hold.
- Full plus simultaneous read and write: both accepted, count stays DEPTH, no overflow.
- Empty plus simultaneous read and write: write accepted and count becomes 1. The read is rejected and underflow sets.
- Write while full with no read: data dropped, memory and count unchanged, overflow sets.
- Read while empty: count stays 0, underflow sets.
- Sticky flags: set on the edge after the offending cycle. clearErr clears them; a new error in the same cycle as clearErr takes priority (flag ends set).
- All status flags are combinational decodes of the registered count, so there is no extra latency.
- Wrap-around: count never exceeds DEPTH or goes below 0; it is (LOG2_DEPTH+1) bits wide, so it has no aliasing at DEPTH.
- rst asserted mid-stream empties the FIFO on the next edge; a write in that same cycle is discarded.

Test Plan:
1. Defaults: after rst, write 0x11,0x22,0x33 on consecutive cycles -> count 1,2,3. dataOut is 0x11; three reads return 0x11,0x22,0x33 in order; count returns to 0 and dataOut=0.
2. Fill: 16 writes of 0x00..0x0F -> halfFull asserts at count 8, almostFull at 12, full at 16. almostEmpty deasserts at count 3. A 17th write (no read) -> count stays 16, dataOut still 0x00, overflow=1.
3. Full with simultaneous read+write 0xAA -> count stays 16, dataOut becomes 0x01, overflow unchanged. Draining 16 reads ends with 0xAA.
4. Empty: read alone -> underflow=1, count 0. Then read+write 0x5C in the same cycle -> count 1, dataOut 0x5C.
5. With overflow=1, assert clearErr -> overflow=0 next cycle. Repeat with clearErr plus an overflowing write in the same cycle -> overflow remains 1.
6. With count=5 and both error flags set, assert rst together with write -> count=0, overflow=underflow=0, dataOut=0, and the write is not stored.
